// File: rtl/vanilla_load_resp_router_pkg.sv
// rtl/vanilla_load_resp_router_pkg.sv - return packet types, core constants and steering helper
package vanilla_load_resp_router_pkg;

    typedef enum logic [1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } bsg_manycore_return_packet_type_e;

    localparam int RV32_reg_addr_width_gp = 5;

    typedef enum logic [1:0] {
        e_route_int,
        e_route_float,
        e_route_ifetch,
        e_route_drop
    } route_e;

    function automatic route_e route_of(input bsg_manycore_return_packet_type_e pkt_type);
        case (pkt_type)
            e_return_int_wb:   return e_route_int;
            e_return_float_wb: return e_route_float;
            e_return_ifetch:   return e_route_ifetch;
            default:           return e_route_drop;
        endcase
    endfunction

endpackage

// File: rtl/vanilla_load_resp_router_slot.sv
// rtl/vanilla_load_resp_router_slot.sv - one load response holding register with stall counter
module vanilla_load_resp_slot
    import vanilla_load_resp_router_pkg::*;
#(
    parameter data_width_p      = "inv",
    parameter reg_addr_width_p  = 5,
    parameter force_threshold_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        load_v_i,
    input  logic [reg_addr_width_p-1:0] load_rd_i,
    input  logic [data_width_p-1:0]     load_data_i,
    input  logic                        fifo_full_i,
    input  logic                        yumi_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [reg_addr_width_p-1:0] rd_o,
    output logic [data_width_p-1:0]     data_o,
    output logic                        force_o
);

    localparam int cnt_width_lp = $clog2(force_threshold_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(force_threshold_p);

    logic                        v_q, v_d;
    logic [cnt_width_lp-1:0]     cnt_q, cnt_d;
    logic [reg_addr_width_p-1:0] rd_q;
    logic [data_width_p-1:0]     data_q;
    logic                        pop;

    // A yumi without a held response is ignored.
    assign pop     = v_q & yumi_i;
    assign ready_o = ~v_q | yumi_i;

    always_comb begin
        v_d   = v_q;
        cnt_d = cnt_q;
        if (load_v_i) begin
            v_d   = 1'b1;
            cnt_d = '0;
        end else if (pop || !v_q) begin
            v_d   = 1'b0;
            cnt_d = '0;
        end else if (cnt_q != cnt_max_lp) begin
            cnt_d = cnt_q + cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            v_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_v_i) begin
            rd_q   <= load_rd_i;
            data_q <= load_data_i;
        end
    end

    assign v_o     = v_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;
    assign force_o = v_q & (fifo_full_i | (cnt_q == cnt_max_lp));

endmodule

// File: rtl/vanilla_load_resp_router.sv
// rtl/vanilla_load_resp_router.sv - steers endpoint returns into int/float load responses and ifetch
module vanilla_load_resp_router
    import vanilla_load_resp_router_pkg::*;
#(
    parameter data_width_p      = "inv",
    parameter reg_addr_width_p  = 5,
    parameter force_threshold_p = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             returned_v_i,
    input  logic [data_width_p-1:0]          returned_data_i,
    input  logic [reg_addr_width_p-1:0]      returned_reg_id_i,
    input  bsg_manycore_return_packet_type_e returned_pkt_type_i,
    input  logic                             returned_fifo_full_i,
    output logic                             returned_yumi_o,
    output logic                             int_resp_v_o,
    output logic [reg_addr_width_p-1:0]      int_resp_rd_o,
    output logic [data_width_p-1:0]          int_resp_data_o,
    output logic                             int_resp_force_o,
    input  logic                             int_resp_yumi_i,
    output logic                             float_resp_v_o,
    output logic [reg_addr_width_p-1:0]      float_resp_rd_o,
    output logic [data_width_p-1:0]          float_resp_data_o,
    output logic                             float_resp_force_o,
    input  logic                             float_resp_yumi_i,
    output logic                             ifetch_v_o,
    output logic [data_width_p-1:0]          ifetch_instr_o,
    output logic                             invalid_pkt_o
);

    route_e route;
    logic   int_ready, float_ready, accept_ok;
    logic   int_load, float_load, ifetch_load, drop_load;
    logic   ifetch_v_q, ifetch_v_d;
    logic   invalid_q, invalid_d;
    logic [data_width_p-1:0] instr_q;

    assign route = route_of(returned_pkt_type_i);

    // Writeback classes need room in their slot; ifetch and dropped types always drain.
    always_comb begin
        accept_ok = 1'b1;
        case (route)
            e_route_int:   accept_ok = int_ready;
            e_route_float: accept_ok = float_ready;
            default:       accept_ok = 1'b1;
        endcase
    end

    assign returned_yumi_o = reset_n_i & returned_v_i & accept_ok;
    assign int_load        = returned_yumi_o & (route == e_route_int);
    assign float_load      = returned_yumi_o & (route == e_route_float);
    assign ifetch_load     = returned_yumi_o & (route == e_route_ifetch);
    assign drop_load       = returned_yumi_o & (route == e_route_drop);

    vanilla_load_resp_slot #(
        .data_width_p      (data_width_p),
        .reg_addr_width_p  (reg_addr_width_p),
        .force_threshold_p (force_threshold_p)
    ) int_slot (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_v_i    (int_load),
        .load_rd_i   (returned_reg_id_i),
        .load_data_i (returned_data_i),
        .fifo_full_i (returned_fifo_full_i),
        .yumi_i      (int_resp_yumi_i),
        .ready_o     (int_ready),
        .v_o         (int_resp_v_o),
        .rd_o        (int_resp_rd_o),
        .data_o      (int_resp_data_o),
        .force_o     (int_resp_force_o)
    );

    vanilla_load_resp_slot #(
        .data_width_p      (data_width_p),
        .reg_addr_width_p  (reg_addr_width_p),
        .force_threshold_p (force_threshold_p)
    ) float_slot (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_v_i    (float_load),
        .load_rd_i   (returned_reg_id_i),
        .load_data_i (returned_data_i),
        .fifo_full_i (returned_fifo_full_i),
        .yumi_i      (float_resp_yumi_i),
        .ready_o     (float_ready),
        .v_o         (float_resp_v_o),
        .rd_o        (float_resp_rd_o),
        .data_o      (float_resp_data_o),
        .force_o     (float_resp_force_o)
    );

    assign ifetch_v_d = ifetch_load;
    assign invalid_d  = invalid_q | drop_load;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ifetch_v_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            ifetch_v_q <= ifetch_v_d;
            invalid_q  <= invalid_d;
        end
    end

    // Instruction word persists until the next ifetch return, across resets.
    always_ff @(posedge clk_i) begin
        if (ifetch_load) begin
            instr_q <= returned_data_i;
        end
    end

    assign ifetch_v_o     = ifetch_v_q;
    assign ifetch_instr_o = instr_q;
    assign invalid_pkt_o  = invalid_q;

endmodule

// File: tb/tb_vanilla_load_resp_router.sv
// tb/tb_vanilla_load_resp_router.sv - self-checking bench for vanilla_load_resp_router
module tb_vanilla_load_resp_router;
    import vanilla_load_resp_router_pkg::*;

    localparam int DW = 32;
    localparam int RW = RV32_reg_addr_width_gp;
    localparam int TH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, ret_v, fifo_full, ret_yumi;
    logic [DW-1:0] ret_data;
    logic [RW-1:0] ret_reg;
    bsg_manycore_return_packet_type_e ret_type;
    logic int_v, int_force, int_yumi, fl_v, fl_force, fl_yumi, if_v, invalid;
    logic [RW-1:0] int_rd, fl_rd;
    logic [DW-1:0] int_data, fl_data, instr;

    vanilla_load_resp_router #(
        .data_width_p      (DW),
        .reg_addr_width_p  (RW),
        .force_threshold_p (TH)
    ) dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .returned_v_i         (ret_v),
        .returned_data_i      (ret_data),
        .returned_reg_id_i    (ret_reg),
        .returned_pkt_type_i  (ret_type),
        .returned_fifo_full_i (fifo_full),
        .returned_yumi_o      (ret_yumi),
        .int_resp_v_o         (int_v),
        .int_resp_rd_o        (int_rd),
        .int_resp_data_o      (int_data),
        .int_resp_force_o     (int_force),
        .int_resp_yumi_i      (int_yumi),
        .float_resp_v_o       (fl_v),
        .float_resp_rd_o      (fl_rd),
        .float_resp_data_o    (fl_data),
        .float_resp_force_o   (fl_force),
        .float_resp_yumi_i    (fl_yumi),
        .ifetch_v_o           (if_v),
        .ifetch_instr_o       (instr),
        .invalid_pkt_o        (invalid)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the core should currently see per class.
    bit            m_int_v, m_fl_v, m_if_v, m_invalid, m_instr_known;
    logic [RW-1:0] m_int_rd, m_fl_rd;
    logic [DW-1:0] m_int_data, m_fl_data, m_instr;
    int            m_int_stall, m_fl_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit v, input bsg_manycore_return_packet_type_e t,
                          input logic [RW-1:0] r, input logic [DW-1:0] d);
        ret_v    = v;
        ret_type = t;
        ret_reg  = r;
        ret_data = d;
    endtask

    // Compare against the model with the current inputs, then advance one clock.
    task automatic run_cycle();
        bit exp_y;
        #1;
        if (!reset_n || !ret_v)                 exp_y = 1'b0;
        else if (ret_type == e_return_int_wb)   exp_y = !m_int_v || int_yumi;
        else if (ret_type == e_return_float_wb) exp_y = !m_fl_v || fl_yumi;
        else                                    exp_y = 1'b1;
        chk("returned_yumi", ret_yumi, exp_y);
        chk("int_v", int_v, m_int_v);
        if (m_int_v) begin
            chk("int_rd", int_rd, m_int_rd);
            chk("int_data", int_data, m_int_data);
        end
        chk("int_force", int_force, m_int_v && (fifo_full || m_int_stall >= TH));
        chk("float_v", fl_v, m_fl_v);
        if (m_fl_v) begin
            chk("float_rd", fl_rd, m_fl_rd);
            chk("float_data", fl_data, m_fl_data);
        end
        chk("float_force", fl_force, m_fl_v && (fifo_full || m_fl_stall >= TH));
        chk("ifetch_v", if_v, m_if_v);
        if (m_instr_known) chk("ifetch_instr", instr, m_instr);
        chk("invalid_pkt", invalid, m_invalid);

        if (!reset_n) begin
            m_int_v = 0; m_fl_v = 0; m_int_stall = 0; m_fl_stall = 0;
            m_if_v = 0; m_invalid = 0;
        end else begin
            if (m_int_v && int_yumi) begin m_int_v = 0; m_int_stall = 0; end
            else if (m_int_v) m_int_stall = (m_int_stall < TH) ? m_int_stall + 1 : TH;
            if (m_fl_v && fl_yumi) begin m_fl_v = 0; m_fl_stall = 0; end
            else if (m_fl_v) m_fl_stall = (m_fl_stall < TH) ? m_fl_stall + 1 : TH;
            m_if_v = 0;
            if (exp_y) begin
                case (ret_type)
                    e_return_int_wb: begin
                        m_int_v = 1; m_int_rd = ret_reg; m_int_data = ret_data; m_int_stall = 0;
                    end
                    e_return_float_wb: begin
                        m_fl_v = 1; m_fl_rd = ret_reg; m_fl_data = ret_data; m_fl_stall = 0;
                    end
                    e_return_ifetch: begin
                        m_if_v = 1; m_instr = ret_data; m_instr_known = 1;
                    end
                    default: m_invalid = 1;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 0; fifo_full = 0; int_yumi = 0; fl_yumi = 0;
        set_in(1, e_return_int_wb, 5'd1, 32'h1);
        m_int_v = 0; m_fl_v = 0; m_if_v = 0; m_invalid = 0; m_instr_known = 0;
        m_int_stall = 0; m_fl_stall = 0;
        @(posedge clk); #1;
        #1;
        chk("reset_yumi_low", ret_yumi, 1'b0);
        run_cycle();
        reset_n = 1;

        // Single int writeback with yumi held high.
        set_in(1, e_return_int_wb, 5'd7, 32'hDEADBEEF);
        int_yumi = 1;
        #1;
        chk("t1_yumi", ret_yumi, 1'b1);
        run_cycle();
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        #1;
        chk("t1_int_v", int_v, 1'b1);
        chk("t1_int_rd", int_rd, 5'd7);
        chk("t1_int_data", int_data, 32'hDEADBEEF);
        chk("t1_int_force", int_force, 1'b0);
        run_cycle();

        // Int slot full and stalled; float still flows.
        int_yumi = 0;
        set_in(1, e_return_int_wb, 5'd3, 32'h1111);
        run_cycle();
        set_in(1, e_return_int_wb, 5'd4, 32'h2222);
        #1;
        chk("t2_int_blocked", ret_yumi, 1'b0);
        run_cycle();
        set_in(1, e_return_float_wb, 5'd9, 32'h3333);
        #1;
        chk("t2_float_accept", ret_yumi, 1'b1);
        run_cycle();
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        #1;
        chk("t2_float_v", fl_v, 1'b1);
        chk("t2_float_data", fl_data, 32'h3333);
        chk("t2_int_data_kept", int_data, 32'h1111);

        // Force after threshold stall cycles.
        int_yumi = 1; fl_yumi = 1;
        run_cycle();
        int_yumi = 0;
        set_in(1, e_return_int_wb, 5'd5, 32'h5555);
        run_cycle();
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        for (int k = 0; k <= TH + 1; k++) begin
            #1;
            chk("t3_force_ramp", int_force, (k >= TH));
            run_cycle();
        end
        int_yumi = 1;
        run_cycle();
        int_yumi = 0;
        #1;
        chk("t3_force_cleared", int_force, 1'b0);

        // FIFO-full forces a pending float only.
        fl_yumi = 0;
        set_in(1, e_return_float_wb, 5'd2, 32'h4444);
        run_cycle();
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        fifo_full = 1;
        #1;
        chk("t4_float_force", fl_force, 1'b1);
        chk("t4_int_no_force", int_force, 1'b0);
        run_cycle();
        fl_yumi = 1;
        run_cycle();
        #1;
        chk("t4_float_idle_force", fl_force, 1'b0);
        fifo_full = 0; fl_yumi = 0;

        // Back-to-back int returns, one response per cycle.
        int_yumi = 1;
        for (int i = 0; i < 6; i++) begin
            set_in(1, e_return_int_wb, RW'(i), 32'hA000 + i);
            #1;
            chk("t5_yumi", ret_yumi, 1'b1);
            if (i > 0) chk("t5_data", int_data, 32'hA000 + i - 1);
            run_cycle();
        end
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        run_cycle();

        // Ifetch pulse, reset mid-stall, then a credit return.
        int_yumi = 0;
        set_in(1, e_return_ifetch, 5'd0, 32'h00000013);
        run_cycle();
        set_in(1, e_return_int_wb, 5'd6, 32'h6666);
        #1;
        chk("t6_ifetch_v", if_v, 1'b1);
        chk("t6_instr", instr, 32'h00000013);
        run_cycle();
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        #1;
        chk("t6_ifetch_once", if_v, 1'b0);
        run_cycle();
        run_cycle();
        reset_n = 0;
        run_cycle();
        reset_n = 1;
        fifo_full = 1;
        #1;
        chk("t6_int_v_reset", int_v, 1'b0);
        chk("t6_int_force_reset", int_force, 1'b0);
        chk("t6_invalid_reset", invalid, 1'b0);
        fifo_full = 0;
        set_in(1, e_return_credit, 5'd0, 32'h0);
        run_cycle();
        set_in(0, e_return_int_wb, 5'd0, 32'h0);
        #1;
        chk("t6_invalid_set", invalid, 1'b1);
        run_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset_n   = ($urandom_range(0, 149) != 0);
            set_in($urandom_range(0, 2) != 0,
                   bsg_manycore_return_packet_type_e'($urandom_range(0, 3)),
                   RW'($urandom), $urandom);
            if ($urandom_range(0, 9) == 0) ret_type = e_return_credit;
            fifo_full = ($urandom_range(0, 15) == 0);
            int_yumi  = ($urandom_range(0, 7) == 0) || (n % 100 < 30 && $urandom_range(0, 1) == 0);
            fl_yumi   = ($urandom_range(0, 5) == 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
